// File: rtl/priv_trap_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : priv_trap_sequencer
// Description : Machine-mode trap/return sequencer. Picks the winning event
//               among synchronous exceptions, interrupts, mret and wfi;
//               emits one-cycle CSR update strobes for trap entry; then
//               holds the redirect request to the pipeline until it
//               reports pipe_clear.
// Ports       :
//   CLK, nRST            clock, synchronous active-low reset
//   fault_insn..env      exception flags from the hazard unit
//   ex_rmgmt(_cause)     RISC-MGMT extension exception and its index
//   ret, wfi             mret / wfi committing
//   pipe_clear           pipeline flushed, redirect may complete
//   epc, badaddr         PC and faulting address/instruction bits
//   ext/soft/timer_int   pending & enabled interrupt sources
//   mstatus_mie          global interrupt enable
//   mtvec, mepc_r        trap vector and current mepc CSR values
//   insert_pc, priv_pc   redirect request and target
//   intr                 current trap is an interrupt
//   *_we, *_wdata        mepc/mcause/mtval write strobes and data
//   mstatus_push/pop     trap-entry / mret stack operations on mstatus
//   sleeping             core halted in wfi
// Revision    : 1.0 - initial release
// ============================================================================
module priv_trap_sequencer #(
  parameter int  NUM_EXT          = 1,
  parameter int  RMGMT_CAUSE_BASE = 24,
  localparam int CW               = (NUM_EXT > 1) ? $clog2(NUM_EXT) : 1
) (
  input  logic          CLK,
  input  logic          nRST,
  input  logic          fault_insn,
  input  logic          mal_insn,
  input  logic          illegal_insn,
  input  logic          fault_l,
  input  logic          mal_l,
  input  logic          fault_s,
  input  logic          mal_s,
  input  logic          breakpoint,
  input  logic          env,
  input  logic          ex_rmgmt,
  input  logic [CW-1:0] ex_rmgmt_cause,
  input  logic          ret,
  input  logic          wfi,
  input  logic          pipe_clear,
  input  logic [31:0]   epc,
  input  logic [31:0]   badaddr,
  input  logic          ext_int,
  input  logic          soft_int,
  input  logic          timer_int,
  input  logic          mstatus_mie,
  input  logic [31:0]   mtvec,
  input  logic [31:0]   mepc_r,
  output logic          insert_pc,
  output logic [31:0]   priv_pc,
  output logic          intr,
  output logic          mepc_we,
  output logic          mcause_we,
  output logic          mtval_we,
  output logic [31:0]   mepc_wdata,
  output logic [31:0]   mcause_wdata,
  output logic [31:0]   mtval_wdata,
  output logic          mstatus_push,
  output logic          mstatus_pop,
  output logic          sleeping
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TRAP_WR  = 3'd1;
  localparam logic [2:0] S_REDIRECT = 3'd2;
  localparam logic [2:0] S_RET      = 3'd3;
  localparam logic [2:0] S_SLEEP    = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  w_next_state;
  logic [31:0] r_cause;
  logic [31:0] r_epc;
  logic [31:0] r_tval;
  logic        r_ret_first;

  logic        w_exc;
  logic        w_int_pend;
  logic        w_irq;
  logic        w_take;
  logic [31:0] w_exc_cause;
  logic [31:0] w_exc_tval;
  logic [31:0] w_irq_cause;
  logic [31:0] w_trap_pc;

  assign w_exc = fault_insn | mal_insn | illegal_insn | fault_l | mal_l |
                 fault_s | mal_s | breakpoint | env | ex_rmgmt;
  // Raw pending (ignoring MIE) is what wakes wfi; MIE only gates trapping.
  assign w_int_pend = ext_int | soft_int | timer_int;
  assign w_irq      = mstatus_mie & w_int_pend;
  assign w_take     = (r_state == S_IDLE) & (w_exc | w_irq);

  // Exception cause and tval selection, highest priority first.
  always_comb begin
    w_exc_cause = 32'd0;
    w_exc_tval  = 32'd0;
    if (fault_insn) begin
      w_exc_cause = 32'd1;  w_exc_tval = badaddr;
    end else if (illegal_insn) begin
      w_exc_cause = 32'd2;  w_exc_tval = badaddr;
    end else if (mal_insn) begin
      w_exc_cause = 32'd0;  w_exc_tval = badaddr;
    end else if (env) begin
      w_exc_cause = 32'd11; w_exc_tval = 32'd0;
    end else if (breakpoint) begin
      w_exc_cause = 32'd3;  w_exc_tval = epc;
    end else if (mal_s) begin
      w_exc_cause = 32'd6;  w_exc_tval = badaddr;
    end else if (mal_l) begin
      w_exc_cause = 32'd4;  w_exc_tval = badaddr;
    end else if (fault_s) begin
      w_exc_cause = 32'd7;  w_exc_tval = badaddr;
    end else if (fault_l) begin
      w_exc_cause = 32'd5;  w_exc_tval = badaddr;
    end else if (ex_rmgmt) begin
      w_exc_cause = 32'(RMGMT_CAUSE_BASE) + 32'(ex_rmgmt_cause);
      w_exc_tval  = 32'd0;
    end
  end

  assign w_irq_cause = ext_int  ? 32'h8000_000B :
                       soft_int ? 32'h8000_0003 :
                                  32'h8000_0007;

  // Vectored mode only offsets interrupts; modes 2/3 fall back to direct.
  assign w_trap_pc = ((mtvec[1:0] == 2'b01) && r_cause[31]) ?
                     ({mtvec[31:2], 2'b00} + {r_cause[29:0], 2'b00}) :
                     {mtvec[31:2], 2'b00};

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Trap context latch and first-RET-cycle marker
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_cause     <= 32'd0;
      r_epc       <= 32'd0;
      r_tval      <= 32'd0;
      r_ret_first <= 1'b0;
    end else begin
      if (w_take) begin
        r_cause <= w_exc ? w_exc_cause : w_irq_cause;
        r_epc   <= epc;
        r_tval  <= w_exc ? w_exc_tval : 32'd0;
      end
      r_ret_first <= (r_state == S_IDLE) && (w_next_state == S_RET);
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_exc || w_irq) begin
          w_next_state = S_TRAP_WR;
        end else if (ret) begin
          w_next_state = S_RET;
        end else if (wfi && !w_int_pend) begin
          w_next_state = S_SLEEP;
        end
      end
      S_TRAP_WR:  w_next_state = S_REDIRECT;
      S_REDIRECT: if (pipe_clear) w_next_state = S_IDLE;
      S_RET:      if (pipe_clear) w_next_state = S_IDLE;
      S_SLEEP:    if (w_int_pend) w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    insert_pc    = 1'b0;
    priv_pc      = 32'd0;
    intr         = 1'b0;
    mepc_we      = 1'b0;
    mcause_we    = 1'b0;
    mtval_we     = 1'b0;
    mepc_wdata   = 32'd0;
    mcause_wdata = 32'd0;
    mtval_wdata  = 32'd0;
    mstatus_push = 1'b0;
    mstatus_pop  = 1'b0;
    sleeping     = 1'b0;
    case (r_state)
      S_TRAP_WR: begin
        mepc_we      = 1'b1;
        mcause_we    = 1'b1;
        mtval_we     = 1'b1;
        mepc_wdata   = r_epc;
        mcause_wdata = r_cause;
        mtval_wdata  = r_tval;
        mstatus_push = 1'b1;
        intr         = r_cause[31];
      end
      S_REDIRECT: begin
        insert_pc = 1'b1;
        priv_pc   = w_trap_pc;
        intr      = r_cause[31];
      end
      S_RET: begin
        insert_pc   = 1'b1;
        priv_pc     = mepc_r;
        mstatus_pop = r_ret_first;
      end
      S_SLEEP: sleeping = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
